// File: rtl/serial_result_rx.sv
// serial_result_rx: receiver for serial result frames.
// Frame: start(0), DATA_W data bits LSB first, optional even parity, stop(1).
// Bit period P = 4*(ConfigDiv+1) clocks; bits are sampled mid-period.
// Good words are buffered in a first-word-fall-through FIFO.
// Optional feature macro: RX_PARITY_EN (defined: parity bit present and checked;
// undefined: no parity bit, o_parity_err tied low).
module serial_result_rx #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned DIV_W      = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_ser_in,
   input  logic [DIV_W-1:0]              i_config_div,
   input  logic                          i_read_en,
   input  logic                          i_clr_ovf,
   output logic [DATA_W-1:0]             o_data_out,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_rx_busy,
   output logic                          o_parity_err,
   output logic                          o_frame_err,
   output logic                          o_overflow
);

   localparam int unsigned CNT_W  = DIV_W + 2;
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StWaitHigh
   } state_e;

   // ------------------------------------------------------------------
   // Line synchroniser and falling-edge detect
   // ------------------------------------------------------------------
   logic r_sync1;
   logic r_sync2;
   logic r_s_prev;
   logic w_s_in;
   logic w_fall;

   // Two-flop synchroniser plus one history flop; reset to the idle level so
   // a start needs a genuine high-to-low transition.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_s_prev <= 1'b1;
      end else begin
         r_sync1  <= i_ser_in;
         r_sync2  <= r_sync1;
         r_s_prev <= r_sync2;
      end
   end

   assign w_s_in = r_sync2;
   assign w_fall = r_s_prev & ~r_sync2;

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   state_e             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [DATA_W-1:0]  r_shift;
   logic               r_rx_busy;
   logic               r_parity_err;
   logic               r_frame_err;
   logic [CNT_W-1:0]   w_period_m1;
   logic               w_par_bad;
   logic               w_push;

   // P-1 = 4*(div+1)-1 = {div, 2'b11}
   assign w_period_m1 = {r_div, 2'b11};

`ifdef RX_PARITY_EN
   logic r_par_bit;

   // Even parity: XOR over data and parity bit must be zero.
   assign w_par_bad = (^r_shift) ^ r_par_bit;
`else
   assign w_par_bad = 1'b0;
`endif

   // Push happens in the stop-sample cycle so the word shows up one cycle later.
   assign w_push = (r_state == StStop) && (r_cnt == '0) && w_s_in && !w_par_bad;

   // Frame sequencing, bit sampling and registered status pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_div        <= '0;
         r_cnt        <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_rx_busy    <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
         r_par_bit    <= 1'b0;
`endif
      end else begin
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_fall) begin
                  // Latch the rate for the whole frame; H-1 = 2*(div+1)-1.
                  r_div     <= i_config_div;
                  r_cnt     <= CNT_W'({i_config_div, 1'b1});
                  r_rx_busy <= 1'b1;
                  r_state   <= StStart;
               end
            end
            StStart: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (!w_s_in) begin
                  r_bit_cnt <= '0;
                  r_cnt     <= w_period_m1;
                  r_state   <= StData;
               end else begin
                  // Line back high at mid-start: treat as a glitch, no error.
                  r_rx_busy <= 1'b0;
                  r_state   <= StIdle;
               end
            end
            StData: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_shift[r_bit_cnt] <= w_s_in;
                  r_cnt              <= w_period_m1;
                  if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef RX_PARITY_EN
                     r_state <= StParity;
`else
                     r_state <= StStop;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
`ifdef RX_PARITY_EN
            StParity: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_par_bit <= w_s_in;
                  r_cnt     <= w_period_m1;
                  r_state   <= StStop;
               end
            end
`endif
            StStop: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_rx_busy <= 1'b0;
                  if (!w_s_in) begin
                     // Framing error wins over parity; wait for line release.
                     r_frame_err <= 1'b1;
                     r_state     <= StWaitHigh;
                  end else begin
                     r_parity_err <= w_par_bad;
                     r_state      <= StIdle;
                  end
               end
            end
            StWaitHigh: begin
               if (w_s_in) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_rx_busy <= 1'b0;
               r_state   <= StIdle;
            end
         endcase
      end
   end

   assign o_rx_busy   = r_rx_busy;
   assign o_frame_err = r_frame_err;
`ifdef RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`else
   assign o_parity_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Received-word FIFO (first-word-fall-through)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [FCNT_W-1:0] r_count;
   logic              r_overflow;
   logic              w_full;
   logic              w_pop;
   logic              w_push_ok;
   logic              w_ovf_set;

   assign w_full    = (r_count == FCNT_W'(FIFO_DEPTH));
   assign w_pop     = i_read_en && (r_count != '0);
   // Pop is applied first, so a full FIFO being popped still has room.
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop;

   // Storage write; contents are don't-care until counted valid.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A new overflow beats a simultaneous clear.
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign o_empty      = (r_count == '0);
   assign o_fifo_count = r_count;
   assign o_overflow   = r_overflow;
   assign o_data_out   = (r_count == '0) ? '0 : r_mem[r_rd_ptr];

endmodule
